axi4lite_slave_regs: RTL and testbench

//   AXI4-Lite subordinate (responder) holding NUM_REGS read/write control registers.

---
 rtl/axi4lite_slave_regs_if.sv | 37 +++
 rtl/axi4lite_slave_regs.sv | 134 +++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_slave_regs_if.sv
// axi4lite_slave_regs_if: AXI4-Lite bus between a manager and the register-bank responder.
interface axi4lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs: AXI4-Lite responder holding NUM_REGS read/write control registers.
// Define AXIL_SLV_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi4lite_slave_regs_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int TOP_LSB  = ADDR_LSB + IDX_W;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    logic                  r_aw_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_wr_ok;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic                  w_rd_ok;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_unused;

    assign w_awready = !r_aw_held && !r_bvalid;
    assign w_wready  = !r_w_held && !r_bvalid;
    assign w_arready = !r_rvalid;
    assign w_aw_hs   = s_axi.awvalid && w_awready;
    assign w_w_hs    = s_axi.wvalid && w_wready;
    assign w_ar_hs   = s_axi.arvalid && w_arready;

    // Commit once both halves are present, whether held from earlier or arriving now
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axi.awaddr;
    assign w_wr_data = r_w_held ? r_w_data : s_axi.wdata;
    assign w_wr_strb = r_w_held ? r_w_strb : s_axi.wstrb;
    assign w_wr_ok   = w_wr_addr[ADDR_WIDTH-1:TOP_LSB] == '0;
    assign w_wr_idx  = w_wr_addr[TOP_LSB-1:ADDR_LSB];
    assign w_wr_sel  = (w_commit && w_wr_ok) ? (NUM_REGS'(1) << w_wr_idx) : '0;
    assign w_rd_ok   = s_axi.araddr[ADDR_WIDTH-1:TOP_LSB] == '0;
    assign w_rd_idx  = s_axi.araddr[TOP_LSB-1:ADDR_LSB];
    assign w_unused  = &{1'b0, s_axi.awprot, s_axi.arprot, w_wr_addr[ADDR_LSB-1:0],
                         s_axi.araddr[ADDR_LSB-1:0]};

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.arready = w_arready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign wr_pulse_o    = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_regs     <= '{default: '0};
            r_wr_pulse <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_aw_held  <= !w_commit && (r_aw_held || w_aw_hs);
            r_w_held   <= !w_commit && (r_w_held || w_w_hs);
            r_wr_pulse <= w_wr_sel;
            if (w_aw_hs)
                r_aw_addr <= s_axi.awaddr;
            if (w_w_hs) begin
                r_w_data <= s_axi.wdata;
                r_w_strb <= s_axi.wstrb;
            end
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < STRB_W; b++)
                    if (w_wr_sel[i] && w_wr_strb[b])
                        r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            // A commit cannot coincide with a pending response: AW/W are stalled while bvalid
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_OOR;
            end else if (s_axi.bready) begin
                r_bvalid <= 1'b0;
            end
            // Sampled before this edge's write lands, so a colliding read sees the old value
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_ok ? r_regs[w_rd_idx] : '0;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_OOR;
            end else if (s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb_axi4lite_slave_regs: vector table plus corner sequences for axi4lite_slave_regs,
// with queued expected B/R responses popped as the responder produces them.
module tb_axi4lite_slave_regs;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_SLV_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic [255:0] regs_o;
    logic [7:0]   wr_pulse_o;
    logic [31:0]  mdl [8];
    logic [1:0]   exp_b [$];
    rexp_t        exp_r [$];
    vec_t         vecs [9];
    int           n_cmp = 0;
    int           n_bad = 0;

    axi4lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axi      (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[31:5] == 27'h0) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
            exp_b.push_back(OKAY);
        end else begin
            exp_b.push_back(OOR);
        end
    endtask

    // Called at the negedge right after the commit edge
    task automatic wait_b(input logic [7:0] pl);
        chk("b_latency", 64'(bus.bvalid), 64'(1));
        if (bus.bvalid) begin
            if (exp_b.size() > 0) chk("bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
            else chk("b_unexpected", 64'(bus.bvalid), 64'(0));
        end
        chk("wr_pulse", 64'(wr_pulse_o), 64'(pl));
        if (bus.bready) begin
            @(negedge aclk);
            chk("bvalid_clear", 64'(bus.bvalid), 64'(0));
            chk("pulse_1cyc", 64'(wr_pulse_o), 64'(0));
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic aw_go, w_go;
        logic [7:0] pl;
        pl = (a[31:5] == 27'h0) ? (8'(1) << a[4:2]) : 8'h0;
        @(negedge aclk);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        model_write(a, d, s);
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_go = bus.awvalid && bus.awready;
            w_go = bus.wvalid && bus.wready;
            @(negedge aclk);
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go) bus.wvalid = 1'b0;
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b(pl);
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n;
        rexp_t e;
        @(negedge aclk);
        bus.araddr = a; bus.arvalid = 1'b1;
        exp_r.push_back('{data: (a[31:5] == 27'h0) ? mdl[a[4:2]] : 32'h0,
                          resp: (a[31:5] == 27'h0) ? OKAY : OOR});
        n = 0;
        while (!bus.arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        chk("r_latency", 64'(bus.rvalid), 64'(1));
        if (bus.rvalid && exp_r.size() > 0) begin
            e = exp_r.pop_front();
            chk("rdata", 64'(bus.rdata), 64'(e.data));
            chk("rresp", 64'(bus.rresp), 64'(e.resp));
        end
        if (bus.rready) begin
            @(negedge aclk);
            chk("rvalid_clear", 64'(bus.rvalid), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] snap;
        rexp_t e;
        vecs[0] = '{32'h00, 32'h0, 4'h0, 0, 32'h0};
        vecs[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 1, 32'hDEADBEEF};
        vecs[1] = '{32'h08, 32'h000000A5, 4'hF, 2, 32'h000000A5};
        vecs[2] = '{32'h1C, 32'hCAFEF00D, 4'hC, 7, 32'hCAFE0000};
        vecs[3] = '{32'h00, 32'h11223344, 4'h5, 0, 32'h00220044};
        vecs[4] = '{32'h08, 32'hFFFFFFFF, 4'h0, 2, 32'h000000A5};
        vecs[5] = '{32'h40, 32'h12345678, 4'hF, -1, 32'h0};
        vecs[6] = '{32'h07, 32'h000000AA, 4'h1, 1, 32'hDEADBEAA};
        vecs[7] = '{32'h1D, 32'h0000AB00, 4'h2, 7, 32'hCAFEAB00};
        vecs[8] = '{32'h20, 32'hFFFFFFFF, 4'hF, -1, 32'h0};
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        aresetn = 1'b0;
        #12;
        chk("rst_bvalid", 64'(bus.bvalid), 64'(0));
        chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
        chk("rst_resp_data", 64'({bus.bresp, bus.rresp, bus.rdata}), 64'(0));
        chk("rst_regs", 64'(|regs_o), 64'(0));
        chk("rst_pulse", 64'(wr_pulse_o), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_rst", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));

        for (int i = 0; i < 8; i++) axi_read(32'(i * 4));

        for (int v = 0; v < 9; v++) begin
            snap = regs_o;
            axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
            if (vecs[v].idx >= 0) chk("vec_reg", 64'(regs_o[vecs[v].idx*32 +: 32]), 64'(vecs[v].exp));
            else chk("vec_oor_nochange", 64'(regs_o == snap), 64'(1));
            axi_read(vecs[v].addr);
        end

        // W three cycles ahead of AW
        @(negedge aclk);
        bus.wdata = 32'h12345678; bus.wstrb = 4'b0011; bus.wvalid = 1'b1;
        chk("wfirst_wready", 64'(bus.wready), 64'(1));
        @(negedge aclk);
        bus.wvalid = 1'b0;
        repeat (2) begin
            chk("wfirst_held", 64'({bus.wready, bus.bvalid, wr_pulse_o}), 64'(0));
            @(negedge aclk);
        end
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        model_write(32'h04, 32'h12345678, 4'b0011);
        chk("wfirst_awready", 64'(bus.awready), 64'(1));
        @(negedge aclk);
        bus.awvalid = 1'b0;
        wait_b(8'h02);
        chk("wfirst_reg1", 64'(regs_o[32 +: 32]), 64'(32'hDEAD5678));

        // Backpressure on B, then on R
        bus.bready = 1'b0;
        axi_write(32'h0C, 32'h0BADF00D, 4'hF);
        repeat (5) begin
            @(negedge aclk);
            chk("bstall", 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 64'({1'b1, OKAY, 2'b00}));
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        chk("bstall_release", 64'(bus.bvalid), 64'(0));
        bus.rready = 1'b0;
        axi_read(32'h0C);
        repeat (5) begin
            @(negedge aclk);
            chk("rstall", 64'({bus.rvalid, bus.arready, bus.rdata}), 64'({2'b10, 32'h0BADF00D}));
        end
        bus.rready = 1'b1;
        @(negedge aclk);
        chk("rstall_release", 64'(bus.rvalid), 64'(0));

        // Read and write commit to reg2 on the same edge
        @(negedge aclk);
        exp_r.push_back('{data: mdl[2], resp: OKAY});
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        model_write(32'h08, 32'h5A5A5A5A, 4'hF);
        chk("coll_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
        @(negedge aclk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("coll_rvalid", 64'(bus.rvalid), 64'(1));
        e = exp_r.pop_front();
        chk("coll_old_data", 64'(bus.rdata), 64'(e.data));
        wait_b(8'h04);
        chk("coll_reg2", 64'(regs_o[64 +: 32]), 64'(32'h5A5A5A5A));

        // Reset while a write response is pending
        axi_write(32'h08, 32'h000000A5, 4'hF);
        bus.bready = 1'b0;
        axi_write(32'h14, 32'h00000077, 4'hF);
        chk("pre_rst_reg2", 64'(regs_o[64 +: 32]), 64'(32'hA5));
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_bvalid", 64'(bus.bvalid), 64'(0));
        chk("async_rst_regs", 64'(|regs_o), 64'(0));
        for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
        bus.bready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("no_resp_after_rst", 64'({bus.bvalid, bus.rvalid}), 64'(0));
        end
        axi_write(32'h08, 32'h0000C3C3, 4'hF);
        chk("post_rst_reg2", 64'(regs_o[64 +: 32]), 64'(32'hC3C3));
        axi_read(32'h08);

        chk("scoreboard_empty", 64'(exp_b.size() + exp_r.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
